// File: rtl/fmt_pkg.sv
// Shared radix encoding, ASCII constants and natural-width helpers for the number formatter.
// Functions are elaboration-time only when called with constant arguments.
package fmt_pkg;

    typedef enum logic [1:0] {
        RADIX_DEC = 2'b00,
        RADIX_BIN = 2'b01,
        RADIX_HEX = 2'b10,
        RADIX_OCT = 2'b11
    } radix_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h61;

    // Decimal digit count of the largest w-bit value, i.e. ceil(w*log10(2)).
    function automatic int nat_width_dec(input int w);
        logic [63:0] v;
        int          n;
        v = {64{1'b1}} >> (64 - w);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                n = n + 1;
                v = v / 64'd10;
            end
        end
        return n;
    endfunction

    function automatic int nat_width(input radix_e r, input int w);
        int n;
        case (r)
            RADIX_DEC: n = nat_width_dec(w);
            RADIX_BIN: n = w;
            RADIX_HEX: n = (w + 3) / 4;
            default:   n = (w + 2) / 3;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (ASCII_ZERO + {4'd0, d}) : (ASCII_A + {4'd0, d} - 8'd10);
    endfunction

endpackage

// File: rtl/div10_serial.sv
// Bit-serial restoring divide-by-10 of a DATA_W-bit value.
// Latency: DATA_W cycles; the start edge performs the first step, busy drops with the last.
// Backpressure: none; start is honoured whenever asserted and restarts any division in flight.
module div10_serial #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    output logic              busy,
    output logic [DATA_W-1:0] quotient,
    output logic [3:0]        remainder
);
    localparam int CNW = $clog2(DATA_W);

    logic [CNW-1:0]    cnt;
    logic [DATA_W-1:0] src_q;
    logic [3:0]        src_r;
    logic [4:0]        trial;
    logic              ge;
    logic [3:0]        r_n;
    logic [DATA_W-1:0] q_n;

    // quotient doubles as the dividend shift register while busy
    always_comb begin
        src_q = start ? dividend : quotient;
        src_r = start ? 4'd0 : remainder;
        trial = {src_r, src_q[DATA_W-1]};
        ge    = (trial >= 5'd10);
        r_n   = ge ? 4'(trial - 5'd10) : trial[3:0];
        q_n   = {src_q[DATA_W-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= CNW'(1);
            quotient  <= q_n;
            remainder <= r_n;
        end else if (busy) begin
            quotient  <= q_n;
            remainder <= r_n;
            cnt       <= cnt + CNW'(1);
            if (cnt == CNW'(DATA_W - 1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ascii_num_formatter.sv
// Formats an unsigned value as an ASCII dec/bin/hex/oct string, optionally padded to natural width.
// Latency: 1 cycle per bin/oct/hex digit, DATA_W cycles per dec digit, then one char per handshake.
// Backpressure: out_char/out_last held while out_ready low; in_ready only when idle.
module ascii_num_formatter
    import fmt_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    input  logic [1:0]        in_radix,
    input  logic              in_pad,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic              out_last
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int IW = $clog2(DATA_W);
    localparam logic [CW-1:0] NAT_DEC = CW'(nat_width(RADIX_DEC, DATA_W));
    localparam logic [CW-1:0] NAT_BIN = CW'(nat_width(RADIX_BIN, DATA_W));
    localparam logic [CW-1:0] NAT_HEX = CW'(nat_width(RADIX_HEX, DATA_W));
    localparam logic [CW-1:0] NAT_OCT = CW'(nat_width(RADIX_OCT, DATA_W));

    typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_EMIT} state_e;

    state_e            state;
    radix_e            radix;
    logic              pad;
    logic [DATA_W-1:0] val;
    logic [CW-1:0]     ndig;
    logic [CW-1:0]     rem_chars;
    logic [3:0]        dig [DATA_W];

    logic              accept, is_dec, conv_step, conv_done;
    logic [3:0]        shift_dig, conv_dig;
    logic [DATA_W-1:0] shift_next;
    logic [CW-1:0]     nat_sel, n_next, total_len;
    logic [7:0]        pad_char, emit_char;
    logic [IW-1:0]     wr_idx, rd_idx;

    logic              div_start, div_busy;
    logic [DATA_W-1:0] div_dividend, div_quo;
    logic [3:0]        div_rem;

    div10_serial #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (div_dividend),
        .busy      (div_busy),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        accept     = in_valid && in_ready;
        is_dec     = (radix == RADIX_DEC);
        shift_dig  = 4'd0;
        shift_next = val;
        nat_sel    = NAT_DEC;
        case (radix)
            RADIX_BIN: begin shift_dig = {3'd0, val[0]};   shift_next = val >> 1; nat_sel = NAT_BIN; end
            RADIX_OCT: begin shift_dig = {1'b0, val[2:0]}; shift_next = val >> 3; nat_sel = NAT_OCT; end
            RADIX_HEX: begin shift_dig = val[3:0];         shift_next = val >> 4; nat_sel = NAT_HEX; end
            default:   begin shift_dig = 4'd0;             shift_next = val;      nat_sel = NAT_DEC; end
        endcase
        conv_step = (state == ST_CONVERT) && (!is_dec || !div_busy);
        conv_dig  = is_dec ? div_rem : shift_dig;
        conv_done = is_dec ? (div_quo == '0) : (shift_next == '0);
        // The divider is kicked on the accepting edge so CONVERT spends exactly DATA_W cycles per dec digit
        div_start    = (accept && (in_radix == RADIX_DEC)) || (conv_step && is_dec && !conv_done);
        div_dividend = (state == ST_IDLE) ? in_value : div_quo;
        n_next    = ndig + CW'(1);
        total_len = pad ? nat_sel : n_next;
        pad_char  = is_dec ? ASCII_SPACE : ASCII_ZERO;
        wr_idx    = IW'(ndig);
        rd_idx    = IW'(rem_chars - CW'(1));
        // rem_chars counts characters still owed; digits occupy the last ndig of them
        emit_char = (rem_chars > ndig) ? pad_char : digit_ascii(dig[rd_idx]);
    end

    always_ff @(posedge clk) begin
        if (conv_step)
            dig[wr_idx] <= conv_dig;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_char  <= 8'h00;
            radix     <= RADIX_DEC;
            pad       <= 1'b0;
            val       <= '0;
            ndig      <= '0;
            rem_chars <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        radix    <= radix_e'(in_radix);
                        pad      <= in_pad;
                        val      <= in_value;
                        ndig     <= '0;
                        state    <= ST_CONVERT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (conv_step) begin
                        ndig <= n_next;
                        val  <= shift_next;
                        if (conv_done) begin
                            state     <= ST_EMIT;
                            out_valid <= 1'b1;
                            rem_chars <= total_len - CW'(1);
                            out_last  <= (total_len == CW'(1));
                            out_char  <= (total_len > n_next) ? pad_char : digit_ascii(conv_dig);
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            out_char  <= emit_char;
                            out_last  <= (rem_chars == CW'(1));
                            rem_chars <= rem_chars - CW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ascii_num_formatter.md
ASCII_NUM_FORMATTER -- requirements
Module: ascii_num_formatter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the input value width; legal range 4..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning a format request is present.
REQ-005 SHALL have port in_ready, output, 1, meaning a request is accepted this cycle.
REQ-006 SHALL have port in_value, input, DATA_W, the unsigned value to format.
REQ-007 SHALL have port in_radix, input, 2, selecting 00 dec, 01 bin, 10 hex, 11 oct.
REQ-008 SHALL have port in_pad, input, 1: 0 gives minimal width, 1 gives natural width.
REQ-009 SHALL have port out_valid, output, 1, meaning out_char is valid.
REQ-010 SHALL have port out_ready, input, 1, the sink's acceptance signal.
REQ-011 SHALL have port out_char, output, 8, one ASCII character.
REQ-012 SHALL have port out_last, output, 1, marking the final character of the string.

Function
REQ-013 SHALL implement states IDLE, CONVERT and EMIT; IDLE goes to CONVERT on in_valid&&in_ready, CONVERT goes to EMIT when conversion is done, and EMIT goes to IDLE when the last character is accepted.
REQ-014 SHALL assert in_ready only in IDLE, and SHALL capture value, radix and pad on the accepting edge.
REQ-015 SHALL generate digits LSB-first into a digit buffer of NAT_W(dec..bin) max entries, continuing until the remaining value is zero, with a minimum of one digit (value 0 gives "0").
REQ-016 SHALL produce bin/oct/hex digits at 1 cycle per digit by shifting 1/3/4 bits; the final oct digit zero-extends.
REQ-017 SHALL produce each dec digit by bit-serial restoring division by 10, taking exactly DATA_W cycles per digit.
REQ-018 SHALL define natural widths as dec ceil(DATA_W*log10 2), bin DATA_W, oct ceil(DATA_W/3), hex ceil(DATA_W/4); for DATA_W=16 these are 5/16/6/4.
REQ-019 SHALL, when in_pad=1, emit (natural width - digit count) pad characters before the digits: space (0x20) for dec, '0' for bin/oct/hex; when in_pad=0, it SHALL emit no pad characters.
REQ-020 SHALL emit digits MSB-first, using '0'-'9' and lowercase 'a'-'f'.
REQ-021 SHALL assert out_valid from the cycle after CONVERT completes, one character per out_valid&&out_ready handshake.
REQ-022 SHALL hold out_char, out_valid and out_last stable while out_valid&&!out_ready, for any stall length.
REQ-023 SHALL assert out_last only with the final digit.
REQ-024 SHALL take in_ready high in the cycle after the last handshake; there is no overlap between consecutive requests.
REQ-025 SHALL ignore in_* changes outside the accept cycle.

Reset
REQ-026 SHALL, on rst, immediately force state IDLE and set out_valid=0, out_last=0, out_char=8'h00 and in_ready=0, with in_ready=1 from the first clock after rst deasserts.
REQ-027 SHALL, if rst asserts mid-CONVERT or mid-EMIT, abort the string with no further characters, and the next request SHALL format normally.

Structure
REQ-028 SHALL place in package fmt_pkg the radix enum (RADIX_DEC/BIN/HEX/OCT), the natural-width functions and the ASCII constants (space, '0', 'a').
REQ-029 SHALL put the bit-serial divide-by-10 in sub-module div10_serial, which provides start, busy, quotient and remainder.

Verification (DATA_W=16, out_ready=1 unless noted)
REQ-030 SHALL cover value 0x001A dec pad=1 -> "   26" (3 spaces), out_last on '6'; with pad=0 -> "26".
REQ-031 SHALL cover value 0x001A bin pad=1 -> "0000000000011010"; bin pad=0 -> "11010"; hex pad=1 -> "001a"; hex pad=0 -> "1a".
REQ-032 SHALL cover value 0xFFFF: dec pad=0 -> "65535" with the first out_valid 80 cycles after CONVERT entry; oct pad=1 -> "177777"; value 0 all radices pad=0 -> "0".
REQ-033 SHALL cover 0x1234 hex pad=0 with out_ready low for 5 cycles after the first character -> '1' held stable, then "234" in order, out_last on '4'.
REQ-034 SHALL cover rst pulsed during the third character of 0xFFFF bin -> out_valid=0 at once, then a new 0x0007 oct pad=0 request -> "7".
